// File: rtl/bpred_btb_if.sv
// Fetch-side bundle between the PC register / ID stage and the branch target buffer.
// The master drives the fetch PC and resolved-branch training; the slave returns prediction and statistics.
interface bpred_btb_if;
    logic        ce;
    logic [31:0] pc;
    logic        branch_or_not;
    logic [31:0] pdt_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pred_cnt;
    logic [31:0] mispred_cnt;

    modport master (
        output ce, pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  branch_or_not, pdt_pc, pred_cnt, mispred_cnt
    );

    modport slave (
        input  ce, pc, upd_valid, upd_pc, upd_taken, upd_target,
        output branch_or_not, pdt_pc, pred_cnt, mispred_cnt
    );
endinterface

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency lookup for the fetch PC; trained by resolved branches from ID.
module bpred_btb #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    bpred_btb_if.slave  bus
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    // Table is flop-based: every entry is cleared on reset and read combinationally.
    logic             r_valid  [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [29:0]      r_target [DEPTH];
    logic [1:0]       r_ctr    [DEPTH];

    logic [31:0] r_pred_cnt;
    logic [31:0] r_mispred_cnt;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_bon;

    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;
    logic [1:0]       w_uctr;
    logic [1:0]       w_uctr_inc;
    logic [1:0]       w_uctr_dec;
    logic             w_upred_taken;
    logic             w_mispred;
    logic             w_unused;

    // Fetch-side lookup
    assign w_idx = bus.pc[IDX_W+1:2];
    assign w_tag = bus.pc[31:IDX_W+2];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_bon = bus.ce & ~rst & w_hit & r_ctr[w_idx][1];

    assign bus.branch_or_not = w_bon;
    assign bus.pdt_pc        = w_bon ? {r_target[w_idx], 2'b00} : 32'h0;

    // Training-side lookup; judged against the table as it stands before this edge
    assign w_uidx        = bus.upd_pc[IDX_W+1:2];
    assign w_utag        = bus.upd_pc[31:IDX_W+2];
    assign w_uhit        = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_uctr        = r_ctr[w_uidx];
    assign w_uctr_inc    = (w_uctr == 2'b11) ? 2'b11 : w_uctr + 2'd1;
    assign w_uctr_dec    = (w_uctr == 2'b00) ? 2'b00 : w_uctr - 2'd1;
    assign w_upred_taken = w_uhit & w_uctr[1];
    assign w_mispred     = (w_upred_taken != bus.upd_taken) |
                           (w_upred_taken & bus.upd_taken &
                            (r_target[w_uidx] != bus.upd_target[31:2]));

    // Byte-offset bits carry no information for word-aligned branches.
    assign w_unused = &{1'b0, bus.upd_pc[1:0], bus.upd_target[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CNT_INIT;
            end
        end else if (bus.upd_valid) begin
            if (w_uhit) begin
                if (bus.upd_taken) begin
                    r_ctr[w_uidx]    <= w_uctr_inc;
                    r_target[w_uidx] <= bus.upd_target[31:2];
                end else begin
                    r_ctr[w_uidx] <= w_uctr_dec;
                end
            end else if (bus.upd_taken) begin
                // Miss on a taken branch evicts whatever occupied the slot.
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= bus.upd_target[31:2];
                r_ctr[w_uidx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_cnt    <= '0;
            r_mispred_cnt <= '0;
        end else if (bus.upd_valid) begin
            if (r_pred_cnt != 32'hFFFF_FFFF) begin
                r_pred_cnt <= r_pred_cnt + 32'd1;
            end
            if (w_mispred && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign bus.pred_cnt    = r_pred_cnt;
    assign bus.mispred_cnt = r_mispred_cnt;
endmodule

// File: tb/tb_bpred_btb.sv
// Self-checking bench for bpred_btb: vector table plus an all-index fill sequence,
// with expected outputs queued at drive time and compared mid-cycle.
module tb_bpred_btb;
    logic clk;
    logic rst;

    bpred_btb_if bus_if ();

    bpred_btb #(
        .IDX_W    (4),
        .CNT_INIT (2'b01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ce;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        ebon;
        logic [31:0] epdt;
        logic [31:0] epc;
        logic [31:0] emc;
    } vec_t;

    typedef struct {
        int          id;
        logic        bon;
        logic [31:0] pdt;
        logic [31:0] pcnt;
        logic [31:0] mcnt;
    } exp_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];
    exp_t exp_q [$];

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input logic r, input logic c, input logic [31:0] p,
                                input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utgt, input logic eb, input logic [31:0] ep,
                                input logic [31:0] epc, input logic [31:0] emc);
        vec_t v;
        v.rst = r;  v.ce = c;  v.pc = p;
        v.uv = uv;  v.upc = upc;  v.ut = ut;  v.utgt = utgt;
        v.ebon = eb;  v.epdt = ep;  v.epc = epc;  v.emc = emc;
        return v;
    endfunction

    task automatic check32(input string name, input int id, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, id, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
    task automatic run_vec(input int id, input vec_t v);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        rst               = v.rst;
        bus_if.ce         = v.ce;
        bus_if.pc         = v.pc;
        bus_if.upd_valid  = v.uv;
        bus_if.upd_pc     = v.upc;
        bus_if.upd_taken  = v.ut;
        bus_if.upd_target = v.utgt;
        e.id = id;  e.bon = v.ebon;  e.pdt = v.epdt;  e.pcnt = v.epc;  e.mcnt = v.emc;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check32("branch_or_not", got.id, {31'b0, bus_if.branch_or_not}, {31'b0, got.bon});
        check32("pdt_pc", got.id, bus_if.pdt_pc, got.pdt);
        check32("pred_cnt", got.id, bus_if.pred_cnt, got.pcnt);
        check32("mispred_cnt", got.id, bus_if.mispred_cnt, got.mcnt);
        $display("vec %0d rst=%b ce=%b pc=%h upd=%b/%h/%b/%h -> bon=%b pdt=%h cnt=%0d/%0d",
                 id, v.rst, v.ce, v.pc, v.uv, v.upc, v.ut, v.utgt,
                 bus_if.branch_or_not, bus_if.pdt_pc, bus_if.pred_cnt, bus_if.mispred_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst               = 1'b1;
        bus_if.ce         = 1'b1;
        bus_if.pc         = 32'h0;
        bus_if.upd_valid  = 1'b0;
        bus_if.upd_pc     = 32'h0;
        bus_if.upd_taken  = 1'b0;
        bus_if.upd_target = 32'h0;
        repeat (2) @(posedge clk);

        //                rst  ce  pc          uv  upc         ut  utgt       bon pdt        pcnt mcnt
        vecs[0]  = mk(1'b1, 1, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0);
        vecs[1]  = mk(1'b0, 1, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0);
        vecs[2]  = mk(1'b0, 1, 32'h40,  1, 32'h40,  1, 32'h100, 0, 32'h0,   0,  0);
        vecs[3]  = mk(1'b0, 1, 32'h40,  0, 32'h0,   0, 32'h0,   1, 32'h100, 1,  1);
        vecs[4]  = mk(1'b0, 1, 32'h40,  1, 32'h40,  1, 32'h100, 1, 32'h100, 1,  1);
        vecs[5]  = mk(1'b0, 1, 32'h40,  1, 32'h40,  1, 32'h100, 1, 32'h100, 2,  1);
        vecs[6]  = mk(1'b0, 1, 32'h40,  1, 32'h40,  1, 32'h100, 1, 32'h100, 3,  1);
        vecs[7]  = mk(1'b0, 1, 32'h40,  1, 32'h40,  0, 32'h0,   1, 32'h100, 4,  1);
        vecs[8]  = mk(1'b0, 1, 32'h40,  0, 32'h0,   0, 32'h0,   1, 32'h100, 5,  2);
        vecs[9]  = mk(1'b0, 1, 32'h40,  1, 32'h40,  0, 32'h0,   1, 32'h100, 5,  2);
        vecs[10] = mk(1'b0, 1, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   6,  3);
        vecs[11] = mk(1'b0, 1, 32'h40,  1, 32'h40,  1, 32'h100, 0, 32'h0,   6,  3);
        vecs[12] = mk(1'b0, 1, 32'h40,  1, 32'h440, 1, 32'h200, 1, 32'h100, 7,  4);
        vecs[13] = mk(1'b0, 1, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   8,  5);
        vecs[14] = mk(1'b0, 1, 32'h440, 0, 32'h0,   0, 32'h0,   1, 32'h200, 8,  5);
        vecs[15] = mk(1'b0, 1, 32'h80,  1, 32'h80,  1, 32'h300, 0, 32'h0,   8,  5);
        vecs[16] = mk(1'b0, 1, 32'h80,  0, 32'h0,   0, 32'h0,   1, 32'h300, 9,  6);
        vecs[17] = mk(1'b0, 1, 32'h80,  1, 32'h80,  1, 32'h380, 1, 32'h300, 9,  6);
        vecs[18] = mk(1'b0, 1, 32'h80,  0, 32'h0,   0, 32'h0,   1, 32'h380, 10, 7);
        vecs[19] = mk(1'b0, 1, 32'h84,  1, 32'h84,  0, 32'h0,   0, 32'h0,   10, 7);
        vecs[20] = mk(1'b0, 1, 32'h84,  0, 32'h0,   0, 32'h0,   0, 32'h0,   11, 7);
        vecs[21] = mk(1'b0, 1, 32'h84,  1, 32'h86,  1, 32'h503, 0, 32'h0,   11, 7);
        vecs[22] = mk(1'b0, 1, 32'h84,  0, 32'h0,   0, 32'h0,   1, 32'h500, 12, 8);
        vecs[23] = mk(1'b0, 0, 32'h84,  1, 32'h84,  0, 32'h0,   0, 32'h0,   12, 8);
        vecs[24] = mk(1'b0, 1, 32'h84,  0, 32'h0,   0, 32'h0,   0, 32'h0,   13, 9);
        vecs[25] = mk(1'b1, 1, 32'h80,  1, 32'hC0,  1, 32'h600, 0, 32'h0,   13, 9);
        vecs[26] = mk(1'b0, 1, 32'h80,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0);
        vecs[27] = mk(1'b0, 1, 32'hC0,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Fill every index with a fresh taken branch, then read each back.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] p;
            logic [31:0] t;
            p = 32'h1000 + 32'(i * 4);
            t = 32'h2000 + 32'(i * 16);
            run_vec(100 + i, mk(1'b0, 1'b1, p, 1'b1, p, 1'b1, t, 1'b0, 32'h0, 32'(i), 32'(i)));
        end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] p;
            logic [31:0] t;
            p = 32'h1000 + 32'(i * 4);
            t = 32'h2000 + 32'(i * 16);
            run_vec(200 + i, mk(1'b0, 1'b1, p, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, t, 32'd16, 32'd16));
        end

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
Branch predictor (the "pdt" unit) that sits directly upstream of the PC register. It supplies `branch_or_not` and `pdt_pc` for the current fetch PC. The block is a direct-mapped branch target buffer with a 2-bit saturating counter per entry, trained by resolved branches from the ID stage. The ID-stage redirect (`branch_flag`) still has priority inside the PC register; this block only supplies the speculative next PC.

Parameters:
- IDX_W, 4: index width; the table holds 2^IDX_W entries.
- CNT_INIT, 2'b01: counter value written to every entry on reset (weak not-taken).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  chip enable from the PC register; when 0, prediction outputs are forced to 0.
- pc  input  32  current fetch PC (word aligned).
- branch_or_not  output  1  predict taken for `pc`.
- pdt_pc  output  32  predicted target; valid only when `branch_or_not` = 1.
- upd_valid  input  1  ID stage resolved a branch or jump this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual direction.
- upd_target  input  32  actual target (meaningful when `upd_taken` = 1).
- pred_cnt  output  32  number of updates processed.
- mispred_cnt  output  32  number of updates judged mispredicted.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - The same split applies to `upd_pc`.
- Entry contents: valid (1 bit), tag (30-IDX_W bits), target[31:2], ctr (2 bits).
  - ctr encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup is combinational from registered table state, with zero-cycle latency, so the PC register samples the prediction at the same edge it updates `pc`.
  - hit = valid[idx] & (tag[idx] == pc tag).
  - `branch_or_not` = ce & ~rst & hit & ctr[idx][1].
  - `pdt_pc` = {target[idx], 2'b00} when `branch_or_not` = 1, else 32'h0.
- Update (on the edge where `upd_valid` = 1), with uhit = hit computed for `upd_pc`:
  - uhit & taken: ctr saturating increment (11 stays 11); target <= upd_target[31:2].
  - uhit & not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - miss & taken: allocate and overwrite the slot: valid=1, tag, target, ctr=2'b10.
  - miss & not taken: no table change.
- Mispredict judgement uses pre-update table state:
  - predicted_taken = uhit & ctr[1].
  - mispredict = (predicted_taken != upd_taken) | (predicted_taken & upd_taken & target != upd_target[31:2]).
- Statistics counters:
  - `pred_cnt` increments on every `upd_valid`.
  - `mispred_cnt` increments on every mispredict.
  - Both saturate at 32'hFFFFFFFF.
- Same-cycle read/write on the same index: lookup returns the old entry; the new value is visible the next cycle.
- `upd_pc` low bits [1:0] are ignored. The `upd_target` low 2 bits are dropped.
- Reset (`rst` = 1 at an edge):
  - all valid <= 0, all ctr <= CNT_INIT, targets and tags <= 0.
  - `pred_cnt` and `mispred_cnt` <= 0.
  - `upd_valid` is ignored during that cycle.
  - While `rst` is high: `branch_or_not` = 0, `pdt_pc` = 0.
- Reset asserted mid-training discards all learned state. The first post-reset lookup is a miss.
- Aliasing: two PCs with the same idx and different tag evict each other on taken allocation. There is no replacement policy beyond overwrite.
- `ce` = 0 gates only the outputs; training still occurs.

Test Plan:
1. Reset, then `pc`=32'h40, no updates -> `branch_or_not`=0, `pdt_pc`=0, both counters 0.
2. Update {pc=32'h40, taken, target=32'h100} once -> next cycle, `pc`=32'h40 gives `branch_or_not`=1, `pdt_pc`=32'h100 (ctr=10). `pred_cnt`=1, `mispred_cnt`=1.
3. Same branch: 3 more taken updates, then 1 not-taken -> ctr 11 then 10, prediction stays taken. Then a second not-taken -> ctr 01, `branch_or_not`=0.
4. Alias (IDX_W=4): train 32'h40 taken to 32'h100, then update 32'h440 taken to 32'h200 -> `pc`=32'h40 misses (`branch_or_not`=0); `pc`=32'h440 predicts 32'h200.
5. Simultaneous: lookup `pc`=32'h80 in the same cycle as the first taken update of 32'h80 -> that cycle `branch_or_not`=0, next cycle 1.
6. Train an entry, assert `rst` for 1 cycle with `upd_valid`=1 -> the entry is gone, counters 0, and the update is ignored. Separately, with `ce`=0 and a hit, outputs are 0.
